// File: rtl/stream_sync_fifo_if.sv
// rtl/stream_sync_fifo_if.sv - valid/ready/data stream bundle
interface stream_sync_fifo_if #(
  parameter int DATA_W = 8
) ();
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/stream_sync_fifo.sv
// rtl/stream_sync_fifo.sv - single-clock FWFT stream FIFO with level, flags, high-water mark and flush
module stream_sync_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  stream_sync_fifo_if.slave        s,
  stream_sync_fifo_if.master       m,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   hwm
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF   = LW'(DEPTH - AF_MARGIN);
  localparam logic [LW-1:0] LVL_AE   = LW'(AE_MARGIN);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level_q;
  logic [LW-1:0]     hwm_q;
  logic [LW-1:0]     level_nxt;
  logic              push;
  logic              pop;

  // Handshake outputs come only from registered level: no s_valid->s_ready
  // or m_ready->m_valid path, and no pass-through when full.
  assign s.ready = (level_q != LVL_FULL);
  assign m.valid = (level_q != '0);
  assign m.data  = mem[rd_ptr];

  assign push = s.valid & s.ready;
  assign pop  = m.valid & m.ready;

  always_comb begin
    level_nxt = level_q;
    case ({push, pop})
      2'b10:   level_nxt = level_q + LW'(1);
      2'b01:   level_nxt = level_q - LW'(1);
      default: level_nxt = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      hwm_q   <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      hwm_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level_q <= level_nxt;
      hwm_q   <= (level_nxt > hwm_q) ? level_nxt : hwm_q;
    end
  end

  // Storage is deliberately left uncleared by rst/flush; only pointers reset.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      mem[wr_ptr] <= s.data;
    end
  end

  assign level        = level_q;
  assign hwm          = hwm_q;
  assign almost_full  = (level_q >= LVL_AF);
  assign almost_empty = (level_q <= LVL_AE);

  a_s_valid_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(s.valid));
  a_m_ready_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(m.ready));
  a_level_range:   assert property (@(posedge clk) disable iff (rst) level_q <= LVL_FULL);
  a_hwm_bound:     assert property (@(posedge clk) disable iff (rst) hwm_q >= level_q);

endmodule

// File: tb/tb_stream_sync_fifo.sv
// tb/tb_stream_sync_fifo.sv - randomized scoreboard bench for stream_sync_fifo
module tb_stream_sync_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AFM   = 2;
  localparam int AEM   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [4:0] level;
  logic [4:0] hwm;
  logic       almost_full;
  logic       almost_empty;

  stream_sync_fifo_if #(.DATA_W(DW)) s_if ();
  stream_sync_fifo_if #(.DATA_W(DW)) m_if ();

  stream_sync_fifo #(
    .DATA_W(DW), .DEPTH(DEPTH), .AF_MARGIN(AFM), .AE_MARGIN(AEM)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s(s_if), .m(m_if),
    .level(level), .almost_full(almost_full), .almost_empty(almost_empty), .hwm(hwm)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mq[$];
  int hwm_m  = 0;
  int total  = 0;
  int bad    = 0;
  int pops   = 0;
  bit pushed = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    check("s_ready",      32'(s_if.ready),    32'(mq.size() != DEPTH));
    check("m_valid",      32'(m_if.valid),    32'(mq.size() != 0));
    check("level",        32'(level),         32'(mq.size()));
    check("hwm",          32'(hwm),           32'(hwm_m));
    check("almost_full",  32'(almost_full),   32'(mq.size() >= DEPTH - AFM));
    check("almost_empty", 32'(almost_empty),  32'(mq.size() <= AEM));
    if (mq.size() != 0) check("m_data", 32'(m_if.data), 32'(mq[0]));
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit r);
    s_if.valid = v;
    s_if.data  = d;
    m_if.ready = r;
  endtask

  // One clock: model decides handshakes from its own occupancy, then updates.
  task automatic cycle();
    bit push, pop;
    push = s_if.valid && (mq.size() != DEPTH);
    pop  = m_if.ready && (mq.size() != 0);
    @(posedge clk);
    pushed = push;
    if (rst || flush) begin
      mq.delete();
      hwm_m = 0;
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        pops++;
      end
      if (push) mq.push_back(s_if.data);
      if (mq.size() > hwm_m) hwm_m = mq.size();
    end
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int target;
    int budget;
    int pv, pr;
    logic [DW-1:0] cnt;

    rst = 1'b1; flush = 1'b0;
    drive(0, 8'h00, 0);
    cycle(); cycle();
    rst = 1'b0;
    check("rst_s_ready", 32'(s_if.ready), 32'd1);
    check("rst_ae",      32'(almost_empty), 32'd1);

    // 1: push 1..5 held, then drain
    for (int i = 1; i <= 5; i++) begin drive(1, DW'(i), 0); cycle(); end
    drive(0, 8'h00, 0); cycle();
    check("t1_level", 32'(level), 32'd5);
    check("t1_hwm",   32'(hwm),   32'd5);
    check("t1_head",  32'(m_if.data), 32'h01);
    drive(0, 8'h00, 1);
    for (int i = 0; i < 6; i++) cycle();
    check("t1_empty", 32'(m_if.valid), 32'd0);
    check("t1_hwm_kept", 32'(hwm), 32'd5);

    // 2: fill to full, hold 0xB0 until a pop frees a slot
    for (int i = 0; i < 16; i++) begin drive(1, 8'hA0 + DW'(i), 0); cycle(); end
    check("t2_full_ready", 32'(s_if.ready), 32'd0);
    check("t2_full_af",    32'(almost_full), 32'd1);
    drive(1, 8'hB0, 0);
    for (int i = 0; i < 3; i++) cycle();
    check("t2_level_held", 32'(level), 32'd16);
    drive(1, 8'hB0, 1); cycle();
    drive(1, 8'hB0, 0); cycle();
    check("t2_level_refill", 32'(level), 32'd16);
    drive(0, 8'h00, 1);
    for (int i = 0; i < 17; i++) cycle();

    // 3: continuous streaming across pointer wraps
    cnt = 8'h00;
    for (int i = 0; i < 40; i++) begin
      drive(1, cnt, 1);
      cycle();
      if (pushed) cnt++;
      check("t3_level", 32'(level), 32'd1);
    end
    drive(0, 8'h00, 1); cycle();

    // 4: flush while a push and pop are both offered
    for (int i = 0; i < 6; i++) begin drive(1, 8'h30 + DW'(i), 0); cycle(); end
    drive(1, 8'h77, 1); flush = 1'b1; cycle();
    flush = 1'b0; drive(0, 8'h00, 0);
    check("t4_level", 32'(level), 32'd0);
    check("t4_hwm",   32'(hwm),   32'd0);
    check("t4_valid", 32'(m_if.valid), 32'd0);
    check("t4_ae",    32'(almost_empty), 32'd1);
    cycle();

    // 5: reset mid-stream at level 9
    for (int i = 0; i < 9; i++) begin drive(1, 8'h60 + DW'(i), 0); cycle(); end
    rst = 1'b1; drive(0, 8'h00, 0); cycle();
    rst = 1'b0;
    check("t5_level", 32'(level), 32'd0);
    check("t5_valid", 32'(m_if.valid), 32'd0);
    drive(1, 8'h55, 0); cycle();
    drive(0, 8'h00, 0);
    check("t5_head", 32'(m_if.data), 32'h55);
    drive(0, 8'h00, 1); cycle(); cycle();

    // 6: random back-pressure, 1000 pops scoreboarded
    target = pops + 1000;
    budget = 0;
    pv = 50; pr = 50;
    while (pops < target && budget < 20000) begin
      if (budget % 150 == 0) begin
        pv = $urandom_range(10, 95);
        pr = $urandom_range(10, 95);
      end
      if (!(s_if.valid && !pushed)) begin
        s_if.valid = ($urandom_range(0, 99) < pv);
        s_if.data  = DW'($urandom);
      end
      m_if.ready = ($urandom_range(0, 99) < pr);
      cycle();
      budget++;
    end
    check("t6_done", 32'(pops >= target), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
